// File: rtl/instr_fetch_memory.sv
// Read-only instruction memory with a 1-deep registered valid/ready response.
// Define IMEM_MISALIGN_CHECK_EN to flag Address[1:0] != 0 as an error.
module instr_fetch_memory #(
  parameter int IDX_W  = 7,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [31:0]       Address,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] Instruction,
  output logic              Error,
  output logic [CNT_W-1:0]  FetchCount
);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic oob;
  logic bad;

  localparam int WIDE_W = DATA_W + IDX_W + 2;

  logic [WIDE_W-1:0] rom_wide;
  logic [DATA_W-1:0] rom_word;

  // Word i holds i*4, so the ROM is just the aligned index.
  assign rom_wide = WIDE_W'({Address[IDX_W+1:2], 2'b00});
  assign rom_word = rom_wide[DATA_W-1:0];

  assign oob = |(Address >> (IDX_W + 2));

`ifdef IMEM_MISALIGN_CHECK_EN
  assign bad = oob || (|Address[1:0]);
`else
  assign bad = oob;
`endif

  assign RspValid = (state == FULL);
  assign ReqReady = !RspValid || RspReady;
  assign accept   = ReqValid && ReqReady;

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (RspReady && !ReqValid) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Response payload only moves on accept; retire-only leaves it as is.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Instruction <= '0;
      Error       <= 1'b0;
      FetchCount  <= '0;
    end else if (accept) begin
      Instruction <= bad ? '0 : rom_word;
      Error       <= bad;
      FetchCount  <= FetchCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch_memory.sv
// Directed bench for instr_fetch_memory.
// A second CNT_W=4 instance shares the stimulus to exercise counter wrap.
module tb_instr_fetch_memory;

  logic        Clk;
  logic        Reset_n;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] Address;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] Instruction;
  logic        Error;
  logic [15:0] FetchCount;

  logic        ReqReady4;
  logic        RspValid4;
  logic [31:0] Instruction4;
  logic        Error4;
  logic [3:0]  FetchCount4;

  int vecs;
  int errs;

  instr_fetch_memory dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .Address     (Address),
    .RspValid    (RspValid),
    .RspReady    (RspReady),
    .Instruction (Instruction),
    .Error       (Error),
    .FetchCount  (FetchCount)
  );

  instr_fetch_memory #(.CNT_W(4)) dut4 (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady4),
    .Address     (Address),
    .RspValid    (RspValid4),
    .RspReady    (RspReady),
    .Instruction (Instruction4),
    .Error       (Error4),
    .FetchCount  (FetchCount4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rsp(
    input string       tag,
    input logic        v,
    input logic [31:0] ins,
    input logic        er,
    input logic [15:0] fc
  );
    check({tag, ".valid"}, 32'(RspValid), 32'(v));
    check({tag, ".instr"}, Instruction, ins);
    check({tag, ".err"}, 32'(Error), 32'(er));
    check({tag, ".count"}, 32'(FetchCount), 32'(fc));
  endtask

  initial begin
    vecs     = 0;
    errs     = 0;
    Reset_n  = 1'b0;
    ReqValid = 1'b0;
    RspReady = 1'b1;
    Address  = 32'h0;
    #1;
    rsp("reset", 1'b0, 32'h0, 1'b0, 16'd0);
    check("reset.ready", 32'(ReqReady), 32'd1);
    tick();
    tick();
    Reset_n = 1'b1;

    // Single fetch
    ReqValid = 1'b1;
    Address  = 32'h0000_000C;
    tick();
    rsp("single", 1'b1, 32'h0000_000C, 1'b0, 16'd1);

    // Back-to-back
    Address = 32'h0;
    tick();
    rsp("b2b0", 1'b1, 32'h0, 1'b0, 16'd2);
    check("b2b0.ready", 32'(ReqReady), 32'd1);
    Address = 32'h4;
    tick();
    rsp("b2b1", 1'b1, 32'h4, 1'b0, 16'd3);
    check("b2b1.ready", 32'(ReqReady), 32'd1);
    Address = 32'h1FC;
    tick();
    rsp("b2b2", 1'b1, 32'h1FC, 1'b0, 16'd4);

    // Retire without request: valid drops, payload holds
    ReqValid = 1'b0;
    tick();
    rsp("drain", 1'b0, 32'h1FC, 1'b0, 16'd4);
    check("drain.ready", 32'(ReqReady), 32'd1);

    // Stall
    ReqValid = 1'b1;
    Address  = 32'h10;
    tick();
    rsp("st_load", 1'b1, 32'h10, 1'b0, 16'd5);
    RspReady = 1'b0;
    Address  = 32'h20;
    #1;
    check("st.ready0", 32'(ReqReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      rsp("st_hold", 1'b1, 32'h10, 1'b0, 16'd5);
      check("st_hold.ready", 32'(ReqReady), 32'd0);
    end
    RspReady = 1'b1;
    #1;
    check("st.ready1", 32'(ReqReady), 32'd1);
    tick();
    rsp("st_next", 1'b1, 32'h20, 1'b0, 16'd6);

    // Out of range and misaligned
    Address = 32'h0000_0200;
    tick();
    rsp("oob", 1'b1, 32'h0, 1'b1, 16'd7);
    Address = 32'h0000_0006;
    tick();
`ifdef IMEM_MISALIGN_CHECK_EN
    rsp("misal", 1'b1, 32'h0, 1'b1, 16'd8);
`else
    rsp("misal", 1'b1, 32'h4, 1'b0, 16'd8);
`endif
    Address = 32'h0000_01FF;
    tick();
`ifdef IMEM_MISALIGN_CHECK_EN
    rsp("last_mis", 1'b1, 32'h0, 1'b1, 16'd9);
`else
    rsp("last_mis", 1'b1, 32'h1FC, 1'b0, 16'd9);
`endif

    // Reset mid-stall
    Address  = 32'h30;
    tick();
    rsp("rst_load", 1'b1, 32'h30, 1'b0, 16'd10);
    RspReady = 1'b0;
    tick();
    rsp("rst_stall", 1'b1, 32'h30, 1'b0, 16'd10);
    #2;
    Reset_n = 1'b0;
    #1;
    rsp("rst_async", 1'b0, 32'h0, 1'b0, 16'd0);
    check("rst_async.cnt4", 32'(FetchCount4), 32'd0);
    ReqValid = 1'b0;
    RspReady = 1'b1;
    tick();
    Reset_n = 1'b1;
    tick();
    rsp("rst_post0", 1'b0, 32'h0, 1'b0, 16'd0);
    tick();
    rsp("rst_post1", 1'b0, 32'h0, 1'b0, 16'd0);

    // Counter wrap on the CNT_W=4 instance
    ReqValid = 1'b1;
    Address  = 32'h8;
    tick();
    rsp("wrap_first", 1'b1, 32'h8, 1'b0, 16'd1);
    for (int i = 0; i < 16; i++) tick();
    check("wrap.cnt16", 32'(FetchCount), 32'd17);
    check("wrap.cnt4", 32'(FetchCount4), 32'd1);
    check("wrap.instr4", Instruction4, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/instr_fetch_memory.md
INSTR_FETCH_MEMORY -- requirements
Module: instr_fetch_memory

Interface
REQ-001 The block SHALL have parameter IDX_W, default 7, meaning word-index width; memory depth SHALL be 2**IDX_W words.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning width of the accepted-fetch counter.
REQ-004 Port Clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 Port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port ReqValid  input  1  fetch request present.
REQ-007 Port ReqReady  output  1  block can accept a request this cycle.
REQ-008 Port Address  input  32  byte address of the requested instruction.
REQ-009 Port RspValid  output  1  Instruction/Error hold a valid response.
REQ-010 Port RspReady  input  1  consumer takes the response this cycle.
REQ-011 Port Instruction  output  DATA_W  fetched word.
REQ-012 Port Error  output  1  response is for an illegal address.
REQ-013 Port FetchCount  output  CNT_W  number of accepted requests since reset.

Function
REQ-014 Memory word i SHALL initialise to (i*4) truncated to DATA_W bits; memory is read-only, with no write port.
REQ-015 Word index SHALL be Address[IDX_W+1:2]; Address[1:0] SHALL select no byte.
REQ-016 ReqReady SHALL equal (!RspValid || RspReady), combinationally.
REQ-017 A request SHALL be accepted on a rising edge where ReqValid && ReqReady.
REQ-018 An accepted request SHALL produce RspValid=1 on the following cycle: latency is exactly 1 cycle, registered output.
REQ-019 Out-of-range: if Address[31:IDX_W+2] != 0, the response SHALL have Error=1 and Instruction=0.
REQ-020 Otherwise, the response SHALL have Error=0 and Instruction=memory[index].
REQ-021 While RspValid=1 && RspReady=0, Instruction, Error and RspValid SHALL hold unchanged and no request SHALL be accepted.
REQ-022 RspValid=1 && RspReady=1 && ReqValid=1 SHALL retire the current response and load the new one in the same edge, sustaining 1 fetch per cycle.
REQ-023 RspValid=1 && RspReady=1 && ReqValid=0 SHALL clear RspValid on that edge; Instruction/Error are don't-care afterwards but SHALL NOT change.
REQ-024 The state machine SHALL have 2 states.
- EMPTY (RspValid=0): goes to FULL on accept.
- FULL (RspValid=1): stays FULL on stall or on retire+accept; goes to EMPTY on retire with no request.
REQ-025 FetchCount SHALL increment by 1 per accepted request, including errored requests, and SHALL wrap from 2**CNT_W-1 to 0.
REQ-026 Address SHALL be sampled only at the accept edge; later Address changes SHALL NOT affect a held response.

Reset
REQ-027 Reset_n=0 SHALL immediately, asynchronously, force RspValid=0, Instruction=0, Error=0, FetchCount=0, state=EMPTY.
REQ-028 Reset asserted while a response is stalled SHALL discard that response; no response SHALL be produced for it after release.
REQ-029 Memory contents SHALL NOT be affected by reset.
REQ-030 The first accept SHALL be possible on the first rising edge after Reset_n deasserts.

Configuration
REQ-031 With macro IMEM_MISALIGN_CHECK_EN defined, an accepted request with Address[1:0] != 0 SHALL respond with Error=1 and Instruction=0; in this case Error is the OR of the misaligned and out-of-range conditions.
REQ-032 Without IMEM_MISALIGN_CHECK_EN, Address[1:0] SHALL be ignored, and Error SHALL reflect out-of-range only.

Verification
REQ-033 Defaults; Address=0x0000000C accepted with RspReady=1 -> next cycle RspValid=1, Instruction=0x0000000C, Error=0, FetchCount=1.
REQ-034 Back-to-back requests to 0x00, 0x04, 0x1FC with RspReady=1 -> Instruction 0x00, 0x04, 0x1FC on 3 consecutive cycles; ReqReady stays 1.
REQ-035 Response 0x10 with RspReady=0 for 3 cycles while Address changes to 0x20 -> ReqReady=0, Instruction holds 0x10; RspReady=1 -> next response is 0x20.
REQ-036 Address=0x00000200 at IDX_W=7 -> Error=1, Instruction=0; Address=0x06 -> with macro Error=1, without macro Instruction=0x04, Error=0.
REQ-037 Reset_n pulsed low mid-stall -> RspValid, Instruction and FetchCount read 0 before the next clock edge; no stale response after release.
REQ-038 CNT_W=4, 17 accepts -> FetchCount=1 (wrapped).
